// File: rtl/tone_pkg.sv
// Shared definitions for the tone player: note codes, pitch table and FSM states.
package tone_pkg;

    localparam int NOTE_W = 4;
    localparam logic [NOTE_W-1:0] NOTE_REST = 4'd14;

    // Pitch in Hz for the playable codes 0..13 (C4 up to B5).
    localparam int unsigned NOTE_HZ [14] = '{
        32'd262, 32'd294, 32'd330, 32'd349, 32'd392, 32'd440, 32'd494,
        32'd523, 32'd587, 32'd659, 32'd698, 32'd784, 32'd880, 32'd988
    };

    typedef enum logic [1:0] {
        MUTE = 2'd0,
        GAP  = 2'd1,
        PLAY = 2'd2
    } state_t;

    // Codes 14 and 15 both mean "rest".
    function automatic logic is_rest(input logic [NOTE_W-1:0] code);
        return (code == 4'd14) || (code == 4'd15);
    endfunction

    // Clock cycles per half period of the square wave; 0 for rest codes.
    function automatic int unsigned half_period(input logic [NOTE_W-1:0] code,
                                                input int unsigned      clk_hz);
        int unsigned hp;
        if (is_rest(code)) begin
            hp = 32'd0;
        end else begin
            hp = clk_hz / (32'd2 * NOTE_HZ[code]);
        end
        return hp;
    endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchroniser for a single asynchronous bit.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture chain; the first stage may go metastable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/tone_player.sv
// Turns the sequencer's note-code stream into a square wave on the piezo pin,
// with a silent articulation gap at the start of every captured note.
module tone_player
    import tone_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int GAP_CYCLES = 500_000,
    parameter int CNT_W      = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              beat,
    input  logic [NOTE_W-1:0] notes,
    input  logic              em,
    input  logic              enable,
    output logic              piezo,
    output logic              playing,
    output logic [NOTE_W-1:0] note_q
);

    localparam bit             GAP_ON   = (GAP_CYCLES > 0);
    localparam logic [CNT_W-1:0] GAP_LAST = GAP_ON ? CNT_W'(GAP_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              beat_sync_s;
    logic              em_sync_s;
    logic [NOTE_W-1:0] notes_sync_s;
    logic              beat_prev_r;
    logic              beat_f_s;
    logic              mute_force_s;

    state_t            state_r;
    state_t            state_nxt_s;
    logic              piezo_r;
    logic              piezo_nxt_s;
    logic              playing_r;
    logic [NOTE_W-1:0] note_q_r;
    logic [NOTE_W-1:0] note_nxt_s;
    logic [CNT_W-1:0]  gap_cnt_r;
    logic [CNT_W-1:0]  gap_nxt_s;
    logic [CNT_W-1:0]  div_cnt_r;
    logic [CNT_W-1:0]  div_nxt_s;
    logic [CNT_W-1:0]  hp_tab_s [16];
    logic [CNT_W-1:0]  hp_last_s;

    sync2 u_sync_beat (.clk(clk), .rst(rst), .d(beat), .q(beat_sync_s));
    sync2 u_sync_em   (.clk(clk), .rst(rst), .d(em),   .q(em_sync_s));

    for (genvar b = 0; b < NOTE_W; b++) begin : g_sync_notes
        sync2 u_sync_note (.clk(clk), .rst(rst), .d(notes[b]), .q(notes_sync_s[b]));
    end

    // Half-period table is fully constant; only the lookup costs logic.
    for (genvar g = 0; g < 16; g++) begin : g_hp
        assign hp_tab_s[g] = CNT_W'(half_period(4'(g), unsigned'(CLK_HZ)));
    end

    // Notes are sampled on the falling beat edge, where the sequencer holds them stable.
    assign beat_f_s     = beat_prev_r & ~beat_sync_s;
    assign mute_force_s = em_sync_s | ~enable;
    assign hp_last_s    = hp_tab_s[note_q_r] - CNT_ONE;

    // Next-state, counter and output decode; mute override beats the beat edge.
    always_comb begin
        state_nxt_s = state_r;
        piezo_nxt_s = piezo_r;
        gap_nxt_s   = gap_cnt_r;
        div_nxt_s   = div_cnt_r;
        note_nxt_s  = beat_f_s ? notes_sync_s : note_q_r;

        if (mute_force_s) begin
            state_nxt_s = MUTE;
            piezo_nxt_s = 1'b0;
            gap_nxt_s   = '0;
            div_nxt_s   = '0;
        end else if (beat_f_s) begin
            // Every new beat restarts articulation, even for a repeated code.
            piezo_nxt_s = 1'b0;
            gap_nxt_s   = '0;
            div_nxt_s   = '0;
            if (is_rest(notes_sync_s)) begin
                state_nxt_s = MUTE;
            end else if (GAP_ON) begin
                state_nxt_s = GAP;
            end else begin
                state_nxt_s = PLAY;
            end
        end else begin
            case (state_r)
                MUTE: begin
                    piezo_nxt_s = 1'b0;
                end
                GAP: begin
                    piezo_nxt_s = 1'b0;
                    if (gap_cnt_r == GAP_LAST) begin
                        state_nxt_s = PLAY;
                        gap_nxt_s   = '0;
                        div_nxt_s   = '0;
                    end else begin
                        gap_nxt_s = gap_cnt_r + CNT_ONE;
                    end
                end
                PLAY: begin
                    if (div_cnt_r == hp_last_s) begin
                        div_nxt_s   = '0;
                        piezo_nxt_s = ~piezo_r;
                    end else begin
                        div_nxt_s = div_cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt_s = MUTE;
                    piezo_nxt_s = 1'b0;
                    gap_nxt_s   = '0;
                    div_nxt_s   = '0;
                end
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_prev_r <= 1'b0;
            state_r     <= MUTE;
            piezo_r     <= 1'b0;
            playing_r   <= 1'b0;
            note_q_r    <= NOTE_REST;
            gap_cnt_r   <= '0;
            div_cnt_r   <= '0;
        end else begin
            beat_prev_r <= beat_sync_s;
            state_r     <= state_nxt_s;
            piezo_r     <= piezo_nxt_s;
            playing_r   <= (state_nxt_s == PLAY);
            note_q_r    <= note_nxt_s;
            gap_cnt_r   <= gap_nxt_s;
            div_cnt_r   <= div_nxt_s;
        end
    end

    assign piezo   = piezo_r;
    assign playing = playing_r;
    assign note_q  = note_q_r;

endmodule

// File: tb/tb_tone_player.sv
// Randomised self-checking bench for tone_player against a note-timeline model.
module tb_tone_player;

    localparam int CLK_HZ     = 1_000_000;
    localparam int GAP_CYCLES = 100;
    localparam int CNT_W      = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       beat;
    logic [3:0] notes;
    logic       em;
    logic       enable;
    logic       piezo;
    logic       playing;
    logic [3:0] note_q;

    int check_cnt = 0;
    int fail_cnt  = 0;

    tone_player #(
        .CLK_HZ    (CLK_HZ),
        .GAP_CYCLES(GAP_CYCLES),
        .CNT_W     (CNT_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .beat   (beat),
        .notes  (notes),
        .em     (em),
        .enable (enable),
        .piezo  (piezo),
        .playing(playing),
        .note_q (note_q)
    );

    always #5 clk = ~clk;

    // Reference pitches, written out independently of the design package.
    int pitch_hz [14] = '{262, 294, 330, 349, 392, 440, 494, 523, 587, 659, 698, 784, 880, 988};

    // Model: pins seen at the last three clock edges, plus note timeline.
    bit       hb [1:3];
    bit       he [1:3];
    bit [3:0] hn [1:3];
    bit       m_snd;
    int       m_k;
    int       m_hp;
    bit [3:0] m_note;

    function automatic int ref_hp(input bit [3:0] code);
        if (code >= 4'd14) return 0;
        return CLK_HZ / (2 * pitch_hz[code]);
    endfunction

    function automatic bit exp_playing();
        return m_snd && (m_k >= GAP_CYCLES);
    endfunction

    function automatic bit exp_piezo();
        if (!exp_playing() || m_hp == 0) return 1'b0;
        return (((m_k - GAP_CYCLES) / m_hp) % 2) == 1;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the pin values present at that edge.
    task automatic model_step();
        bit       bf;
        bit       es;
        bit [3:0] ns;
        if (rst) begin
            for (int i = 1; i <= 3; i++) begin
                hb[i] = 1'b0; he[i] = 1'b0; hn[i] = 4'd0;
            end
            m_snd  = 1'b0;
            m_k    = 0;
            m_hp   = 0;
            m_note = 4'd14;
        end else begin
            bf = hb[3] && !hb[2];
            es = he[2];
            ns = hn[2];
            if (bf) m_note = ns;
            if (es || !enable) begin
                m_snd = 1'b0;
            end else if (bf) begin
                if (ns >= 4'd14) begin
                    m_snd = 1'b0;
                end else begin
                    m_snd = 1'b1;
                    m_k   = 0;
                    m_hp  = ref_hp(ns);
                end
            end else if (m_snd) begin
                m_k++;
            end
            hb[3] = hb[2]; he[3] = he[2]; hn[3] = hn[2];
            hb[2] = hb[1]; he[2] = he[1]; hn[2] = hn[1];
            hb[1] = beat;  he[1] = em;    hn[1] = notes;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_eq("playing", playing, exp_playing());
        check_eq("piezo", piezo, exp_piezo());
        check_eq("note_q", note_q, m_note);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic beat_pulse(input bit [3:0] code, input int hi, input int lo);
        notes = code;
        beat  = 1'b1;
        wait_cycles(hi);
        beat  = 1'b0;
        wait_cycles(lo);
    endtask

    initial begin
        int n;
        rst    = 1'b1;
        beat   = 1'b0;
        notes  = 4'd0;
        em     = 1'b0;
        enable = 1'b1;

        // Reset state, then a single A4 beat.
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(20);
        beat_pulse(4'd5, 50, 3000);

        // Repeated D5 gets a fresh gap; rest code mutes.
        beat_pulse(4'd8, 400, 1800);
        beat_pulse(4'd8, 400, 1800);
        beat_pulse(4'd14, 400, 600);

        // End-of-music mutes and does not resume without a new beat.
        beat_pulse(4'd7, 400, 1200);
        em = 1'b1;
        wait_cycles(300);
        em = 1'b0;
        wait_cycles(500);
        beat_pulse(4'd7, 400, 1500);

        // Disabled player stays silent but still tracks note codes.
        enable = 1'b0;
        beat_pulse(4'd10, 400, 800);
        beat_pulse(4'd10, 400, 800);
        enable = 1'b1;

        // Asynchronous reset while the wave is high.
        beat_pulse(4'd4, 400, 0);
        n = 0;
        while (!exp_piezo() && n < 3000) begin
            tick();
            n++;
        end
        check_eq("rst_wait_piezo_high", piezo, 1);
        rst = 1'b1;
        #1;
        check_eq("rst_async_piezo", piezo, 0);
        check_eq("rst_async_playing", playing, 0);
        check_eq("rst_async_note_q", note_q, 4'd14);
        wait_cycles(5);
        rst = 1'b0;
        wait_cycles(600);

        // Rest code 15, then B5 with a beat edge landing on a terminal count.
        beat_pulse(4'd15, 400, 500);
        beat_pulse(4'd13, 400, 1500);
        notes = 4'd13;
        beat  = 1'b1;
        wait_cycles(200);
        n = 0;
        while (!(m_snd && (m_k + 2 >= GAP_CYCLES) &&
                 (((m_k + 3 - GAP_CYCLES) % m_hp) == 0)) && n < 3000) begin
            tick();
            n++;
        end
        check_eq("tc_align_found", (n < 3000), 1);
        beat = 1'b0;
        wait_cycles(3);
        check_eq("tc_restart_piezo", piezo, 0);
        check_eq("tc_restart_playing", playing, 0);
        wait_cycles(1200);

        // Random beats with occasional mute overrides.
        for (int i = 0; i < 6; i++) begin
            enable = ($urandom_range(0, 4) != 0);
            em     = ($urandom_range(0, 4) == 0);
            notes  = 4'($urandom_range(0, 15));
            beat   = 1'b1;
            wait_cycles($urandom_range(300, 900));
            beat   = 1'b0;
            wait_cycles($urandom_range(100, 400));
            em     = 1'b0;
            enable = 1'b1;
            wait_cycles($urandom_range(600, 1500));
        end

        $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/tone_player.md
Name: tone_player

Overview:
- Consumer end of the 4-bit note-code stream driven by the song sequencers (notes / em interface); converts each code into a square wave on the piezo pin.
- Samples the code once per beat from the sequencer's slow beat clock and inserts a short articulation gap so that repeated notes stay distinct.
- Mutes on rest codes, on end-of-music and when disabled.
- Sits between the song sequencers and the board buzzer output.

Parameters:
- CLK_HZ, 50_000_000, frequency of clk in Hz; used for all half-period constants.
- GAP_CYCLES, 500_000, silent cycles at the start of every captured note; 0 disables the gap.
- CNT_W, 20, width of the divider and gap counters; must hold max(CLK_HZ/524, GAP_CYCLES).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- beat  in  1  sequencer beat clock, asynchronous to clk; the sequencer updates notes on its rising edge
- notes  in  4  note code from sequencer, asynchronous to clk
- em  in  1  end-of-music flag from sequencer, asynchronous to clk
- enable  in  1  synchronous to clk; 0 forces mute
- piezo  out  1  square-wave drive
- playing  out  1  high while piezo is toggling
- note_q  out  4  currently latched note code

Behaviour:
- Reset values: piezo=0, playing=0, note_q=4'd14 (rest), state=MUTE, all counters 0, all synchroniser flops 0.
- Synchronisation: beat, notes[3:0] and em each pass through a 2-flop synchroniser. beat_f is the falling edge of synced beat (previous synced value 1, current 0).
- Capture: on beat_f, note_q <= synced notes. The falling edge is used because notes is stable mid-beat.
- Code map, in Hz: 0=262, 1=294, 2=330, 3=349, 4=392, 5=440, 6=494, 7=523, 8=587, 9=659, 10=698, 11=784, 12=880, 13=988. Codes 14 and 15 are rest.
- Half period: HP(code) = CLK_HZ/(2*f), integer truncation, evaluated at elaboration.
- State machine MUTE / GAP / PLAY:
  - MUTE: piezo=0, playing=0. On beat_f with enable=1, em=0 and a non-rest code: go to GAP, load gap_cnt=0.
  - GAP: piezo=0, playing=0. gap_cnt increments. When gap_cnt==GAP_CYCLES-1, go to PLAY with div_cnt=0. If GAP_CYCLES=0, go directly MUTE/PLAY to PLAY.
  - PLAY: playing=1. div_cnt increments; when div_cnt==HP(note_q)-1, set div_cnt=0 and toggle piezo. First toggle to 1 occurs HP cycles after entering PLAY.
  - beat_f in GAP or PLAY with a non-rest code: restart GAP, piezo=0, div_cnt=0. This applies even if the code is unchanged.
  - beat_f with a rest code: go to MUTE.
- Override priority: rst > (em synced=1 or enable=0) > beat_f.
  - em or !enable forces MUTE and piezo=0 within 1 cycle of the synced value. note_q still updates on beat_f.
  - Leaving em/!enable does not resume the tone; it waits for the next beat_f.
- Latency: notes/beat pin change to beat_f is 3 clk cycles. beat_f to GAP entry is 1 cycle.
- Boundaries:
  - div_cnt compare uses ==, and div_cnt is cleared on every state entry, so no wrap.
  - beat_f in the same cycle as a div terminal count: beat_f wins, piezo=0.
  - rst mid-note: immediate silence; all outputs return to reset values.

Decomposition:
- Shared package tone_pkg:
  - constants NOTE_REST=4'd14 and NOTE_W=4;
  - Hz table for codes 0..13;
  - function half_period(code, clk_hz), which returns 0 for codes 14/15;
  - state enumeration {MUTE, GAP, PLAY}.
- One sub-module, sync2: generic 2-flop synchroniser with async active-high reset, instantiated for beat, em and each notes bit.

Test Plan (CLK_HZ=1_000_000, GAP_CYCLES=100):
- Reset release, enable=1, notes=5, one beat pulse -> 3 cycles after the beat falls GAP is entered; piezo stays 0 for 100 cycles, then toggles every 1136 cycles; playing=1; note_q=5.
- Beats carrying 8, 8, 14 -> D5 with toggles every 851 cycles; a 100-cycle silent gap at the second 8 even though the code repeats; the code-14 beat forces MUTE, piezo=0, note_q=14.
- While playing code 7 (HP 956), assert em -> piezo=0, playing=0 within 3 cycles. Deassert em with no beat -> stays MUTE. Next beat with code 7 -> gap then tone.
- enable=0 throughout, beats with code 10 -> piezo never toggles; note_q=10.
- Assert rst mid-PLAY -> piezo=0, playing=0, note_q=14 immediately. After release, silence until the next beat.
- Code 15 and code 13 (HP 506): code 15 -> mute; code 13 -> toggles exactly every 506 cycles. beat_f on a terminal-count cycle -> piezo=0, GAP restarts.
